vga_text_writer: RTL and testbench



---
 rtl/vga_text_writer_pkg.sv | 24 ++
 rtl/vga_cursor.sv | 64 ++++++
 rtl/vga_text_writer.sv | 151 +++++++++++++++
 tb/tb_vga_text_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_writer_pkg.sv
// Shared definitions for the 40x30 text-mode VRAM writer: control codes,
// FSM state encoding and default screen geometry.
`default_nettype none

package vga_text_writer_pkg;

  localparam int DEF_COLS = 40;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLR_LINE   = 2'd1,
    ST_CLR_SCREEN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_cursor.sv
// Cursor column/row counters plus a running line base (row*COLS) so the
// writer never needs a multiplier.
`default_nettype none

module vga_cursor
  import vga_text_writer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_newline,
  input  logic          i_home,
  input  logic          i_bs,
  input  logic          i_cr,
  output logic [5:0]    o_col,
  output logic [4:0]    o_row,
  output logic [AW-1:0] o_base,
  output logic [AW-1:0] o_nl_base
);

  logic [5:0]    r_col;
  logic [4:0]    r_row;
  logic [AW-1:0] r_base;
  logic          w_last_row;
  logic [AW-1:0] w_nl_base;

  assign w_last_row = (r_row == 5'(ROWS - 1));
  // Base of the row a newline lands on; the writer also uses it to start the line clear early.
  assign w_nl_base  = w_last_row ? '0 : r_base + AW'(COLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
    end else if (i_home) begin
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
    end else if (i_newline) begin
      r_col  <= '0;
      r_row  <= w_last_row ? '0 : r_row + 5'd1;
      r_base <= w_nl_base;
    end else if (i_inc) begin
      r_col <= r_col + 6'd1;
    end else if (i_bs && (r_col != 6'd0)) begin
      r_col <= r_col - 6'd1;
    end else if (i_cr) begin
      r_col <= '0;
    end
  end

  assign o_col     = r_col;
  assign o_row     = r_row;
  assign o_base    = r_base;
  assign o_nl_base = w_nl_base;

endmodule

`default_nettype wire

// File: rtl/vga_text_writer.sv
// Byte-stream front end for the text VRAM: decodes printable/control bytes,
// tracks the cursor and performs line and screen clears through the write port.
`default_nettype none

module vga_text_writer
  import vga_text_writer_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter int         AW    = 11,
  parameter logic [7:0] BLANK = CH_BLANK
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic [5:0]    cur_col,
  output logic [4:0]    cur_row
);

  localparam logic [AW-1:0] LAST_LINE   = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_SCREEN = AW'(COLS * ROWS - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ready;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wdata;

  logic [5:0]    w_col;
  logic [4:0]    w_row;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_nl_base;
  logic [AW-1:0] w_cur_addr;
  logic          w_accept;
  logic          w_print;
  logic          w_eol;

  assign w_accept   = in_valid && r_ready;
  assign w_print    = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_eol      = (w_col == 6'(COLS - 1));
  assign w_cur_addr = w_base + AW'(w_col);

  vga_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW)
  ) u_cursor (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_inc     (w_accept && w_print && !w_eol),
    .i_newline (w_accept && ((w_print && w_eol) || (in_data == CH_LF))),
    .i_home    (w_accept && (in_data == CH_FF)),
    .i_bs      (w_accept && (in_data == CH_BS)),
    .i_cr      (w_accept && (in_data == CH_CR)),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_base    (w_base),
    .o_nl_base (w_nl_base)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLR_SCREEN;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= BLANK;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_ready) begin
            // One settling cycle after a clear so ready never overlaps its last write.
            r_ready <= 1'b1;
          end else if (w_accept) begin
            if (w_print) begin
              r_we    <= 1'b1;
              r_waddr <= w_cur_addr;
              r_wdata <= in_data;
              if (w_eol) begin
                r_state <= ST_CLR_LINE;
                r_cnt   <= '0;
                r_ready <= 1'b0;
              end
            end else begin
              case (in_data)
                CH_LF: begin
                  // First blank of the new row goes out with the cursor move.
                  r_we    <= 1'b1;
                  r_waddr <= w_nl_base;
                  r_wdata <= BLANK;
                  r_cnt   <= AW'(1);
                  r_state <= ST_CLR_LINE;
                  r_ready <= 1'b0;
                end
                CH_BS: begin
                  if (w_col != 6'd0) begin
                    r_we    <= 1'b1;
                    r_waddr <= w_cur_addr - AW'(1);
                    r_wdata <= BLANK;
                  end
                end
                CH_FF: begin
                  r_we    <= 1'b1;
                  r_waddr <= '0;
                  r_wdata <= BLANK;
                  r_cnt   <= AW'(1);
                  r_state <= ST_CLR_SCREEN;
                  r_ready <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CLR_LINE: begin
          r_we    <= 1'b1;
          r_waddr <= w_base + r_cnt;
          r_wdata <= BLANK;
          if (r_cnt == LAST_LINE) r_state <= ST_IDLE;
          else                    r_cnt   <= r_cnt + AW'(1);
        end
        ST_CLR_SCREEN: begin
          r_we    <= 1'b1;
          r_waddr <= r_cnt;
          r_wdata <= BLANK;
          if (r_cnt == LAST_SCREEN) r_state <= ST_IDLE;
          else                      r_cnt   <= r_cnt + AW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign vram_we    = r_we;
  assign vram_waddr = r_waddr;
  assign vram_wdata = r_wdata;
  assign cur_col    = w_col;
  assign cur_row    = w_row;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: a vector table for single-byte behaviour
// plus hand sequences for clears, wraps and reset abort.
`default_nettype none

module tb_vga_text_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       we;
    int         addr;
    logic [7:0] wd;
    int         col;
    int         row;
  } vec_t;

  vec_t vecs[10];

  vga_text_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .cur_col    (cur_col),
    .cur_row    (cur_row)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Waits for ready, presents the byte for one accept edge, returns at the
  // falling edge after the accept (where that byte's effects are visible).
  task automatic put(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("put_ready_timeout", 0, 1);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expects n consecutive blank writes at first.. with ready held low.
  task automatic clear_run(input int first, input int n, input string nm);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!(vram_we === 1'b1 && int'(vram_waddr) == first + i &&
            vram_wdata === 8'h20 && in_ready === 1'b0)) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    int bad;

    vecs[0] = '{8'h48, 1'b1, 0, 8'h48, 1, 0};
    vecs[1] = '{8'h69, 1'b1, 1, 8'h69, 2, 0};
    vecs[2] = '{8'h0D, 1'b0, 1, 8'h69, 0, 0};
    vecs[3] = '{8'h07, 1'b0, 1, 8'h69, 0, 0};
    vecs[4] = '{8'h78, 1'b1, 0, 8'h78, 1, 0};
    vecs[5] = '{8'h08, 1'b1, 0, 8'h20, 0, 0};
    vecs[6] = '{8'h08, 1'b0, 0, 8'h20, 0, 0};
    vecs[7] = '{8'h7E, 1'b1, 0, 8'h7E, 1, 0};
    vecs[8] = '{8'h7F, 1'b0, 0, 8'h7E, 1, 0};
    vecs[9] = '{8'h41, 1'b1, 1, 8'h41, 2, 0};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we",    int'(vram_we),    0);
    chk("rst_ready", int'(in_ready),   0);
    chk("rst_addr",  int'(vram_waddr), 0);
    chk("rst_data",  int'(vram_wdata), 32);
    chk("rst_col",   int'(cur_col),    0);
    chk("rst_row",   int'(cur_row),    0);

    // Reset abort in the middle of the power-up clear.
    reset_n = 1'b1;
    clear_run(0, 500, "clr_partial");
    reset_n = 1'b0;
    #1;
    chk("abort_we",    int'(vram_we),    0);
    chk("abort_ready", int'(in_ready),   0);
    chk("abort_addr",  int'(vram_waddr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_run(0, 1200, "clr_screen_full");
    @(negedge clk);
    chk("clr_done_ready", int'(in_ready), 1);
    chk("clr_done_we",    int'(vram_we),  0);
    chk("clr_done_col",   int'(cur_col),  0);
    chk("clr_done_row",   int'(cur_row),  0);

    for (int i = 0; i < 10; i++) begin
      put(vecs[i].d);
      chk($sformatf("vec%0d_we", i),    int'(vram_we),    int'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i),  int'(vram_waddr), vecs[i].addr);
      chk($sformatf("vec%0d_data", i),  int'(vram_wdata), int'(vecs[i].wd));
      chk($sformatf("vec%0d_col", i),   int'(cur_col),    vecs[i].col);
      chk($sformatf("vec%0d_row", i),   int'(cur_row),    vecs[i].row);
      chk($sformatf("vec%0d_ready", i), int'(in_ready),   1);
    end

    // 40 printable bytes fill row 0 and wrap into a cleared row 1.
    put(8'h0D);
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      put(8'h41);
      if (!(vram_we === 1'b1 && int'(vram_waddr) == i && vram_wdata === 8'h41)) bad++;
    end
    chk("row0_fill", bad, 0);
    put(8'h41);
    chk("eol_we",    int'(vram_we),    1);
    chk("eol_addr",  int'(vram_waddr), 39);
    chk("eol_data",  int'(vram_wdata), 8'h41);
    chk("eol_col",   int'(cur_col),    0);
    chk("eol_row",   int'(cur_row),    1);
    chk("eol_ready", int'(in_ready),   0);
    clear_run(40, 40, "wrap_clr_line");
    @(negedge clk);
    chk("wrap_done_ready", int'(in_ready), 1);
    chk("wrap_done_we",    int'(vram_we),  0);

    // Walk down to row 29, move to col 5, then LF wraps to row 0.
    for (int i = 0; i < 28; i++) put(8'h0A);
    @(negedge clk);
    chk("lf_walk_row", int'(cur_row), 29);
    chk("lf_walk_col", int'(cur_col), 0);
    for (int i = 0; i < 5; i++) put(8'h42);
    chk("row29_addr", int'(vram_waddr), 1164);
    chk("row29_col",  int'(cur_col),    5);
    put(8'h0A);
    chk("lfwrap_we",    int'(vram_we),    1);
    chk("lfwrap_addr",  int'(vram_waddr), 0);
    chk("lfwrap_data",  int'(vram_wdata), 8'h20);
    chk("lfwrap_col",   int'(cur_col),    0);
    chk("lfwrap_row",   int'(cur_row),    0);
    chk("lfwrap_ready", int'(in_ready),   0);
    clear_run(1, 39, "lfwrap_clr_line");
    @(negedge clk);
    chk("lfwrap_done_ready", int'(in_ready), 1);
    chk("lfwrap_done_we",    int'(vram_we),  0);

    // Backspace at col 3 row 2, then carriage return.
    put(8'h0A);
    put(8'h0A);
    put(8'h61);
    put(8'h62);
    put(8'h63);
    chk("abc_addr", int'(vram_waddr), 82);
    chk("abc_col",  int'(cur_col),    3);
    chk("abc_row",  int'(cur_row),    2);
    put(8'h08);
    chk("bs_we",   int'(vram_we),    1);
    chk("bs_addr", int'(vram_waddr), 82);
    chk("bs_data", int'(vram_wdata), 8'h20);
    chk("bs_col",  int'(cur_col),    2);
    put(8'h0D);
    chk("cr_we",  int'(vram_we),  0);
    chk("cr_col", int'(cur_col),  0);
    chk("cr_row", int'(cur_row),  2);

    // Form feed clears the whole screen and homes the cursor.
    put(8'h0C);
    chk("ff_we",    int'(vram_we),    1);
    chk("ff_addr",  int'(vram_waddr), 0);
    chk("ff_data",  int'(vram_wdata), 8'h20);
    chk("ff_col",   int'(cur_col),    0);
    chk("ff_row",   int'(cur_row),    0);
    chk("ff_ready", int'(in_ready),   0);
    clear_run(1, 1199, "ff_clr_screen");
    @(negedge clk);
    chk("ff_done_ready", int'(in_ready), 1);
    chk("ff_done_we",    int'(vram_we),  0);
    put(8'h07);
    chk("bel_we",    int'(vram_we),    0);
    chk("bel_addr",  int'(vram_waddr), 1199);
    chk("bel_col",   int'(cur_col),    0);
    chk("bel_row",   int'(cur_row),    0);
    chk("bel_ready", int'(in_ready),   1);
    @(negedge clk);
    chk("bel_after_we", int'(vram_we), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
